// File: rtl/mac_issue_ctrl_pkg.sv
// Shared types and constants for the MAC operand issuer.
package mac_issue_ctrl_pkg;

  localparam int unsigned DefWidth  = 32;
  localparam int unsigned DefMaxOut = 16;

  localparam int unsigned ChA   = 0;
  localparam int unsigned ChB   = 1;
  localparam int unsigned ChC   = 2;
  localparam int unsigned ChOp  = 3;
  localparam int unsigned NumCh = 4;

  typedef enum logic {
    StIdle,
    StIssue
  } state_e;

endpackage

// File: rtl/mac_issue_ctrl_if.sv
// Command, MAC operand/answer and result-buffer handshakes of the issuer.
interface mac_issue_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] cmd_a, cmd_b, cmd_c;
  logic             cmd_op, cmd_stb, cmd_ack;

  logic [WIDTH-1:0] mac_a, mac_b, mac_c;
  logic             mac_op;
  logic             mac_a_stb, mac_b_stb, mac_c_stb, mac_op_stb;
  logic             mac_a_ack, mac_b_ack, mac_c_ack, mac_op_ack;

  logic [WIDTH-1:0] mac_ans;
  logic             mac_ans_stb, mac_ans_ack;

  logic [WIDTH-1:0] res_data;
  logic             res_stb, res_ack;

  // Issuer side.
  modport master (
    input  cmd_a, cmd_b, cmd_c, cmd_op, cmd_stb,
    output cmd_ack,
    output mac_a, mac_b, mac_c, mac_op,
    output mac_a_stb, mac_b_stb, mac_c_stb, mac_op_stb,
    input  mac_a_ack, mac_b_ack, mac_c_ack, mac_op_ack,
    input  mac_ans, mac_ans_stb,
    output mac_ans_ack,
    output res_data, res_stb,
    input  res_ack
  );

  // Command source, MAC FIFOs and result consumer.
  modport slave (
    output cmd_a, cmd_b, cmd_c, cmd_op, cmd_stb,
    input  cmd_ack,
    input  mac_a, mac_b, mac_c, mac_op,
    input  mac_a_stb, mac_b_stb, mac_c_stb, mac_op_stb,
    output mac_a_ack, mac_b_ack, mac_c_ack, mac_op_ack,
    output mac_ans, mac_ans_stb,
    input  mac_ans_ack,
    input  res_data, res_stb,
    output res_ack
  );

endinterface

// File: rtl/mac_issue_ctrl_stb_chan_tx.sv
// One operand channel: holds a word with a pend bit until the FIFO takes it.
module stb_chan_tx #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ack_i,
  output logic             stb_o,
  output logic [WIDTH-1:0] data_o,
  output logic             done_now_o
);

  logic             pend_q, pend_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    if (load_i) begin
      pend_d = 1'b1;
      data_d = data_i;
    end else if (pend_q && ack_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign stb_o      = pend_q;
  assign data_o     = data_q;
  // Channel is finished if nothing pending or its word transfers this cycle.
  assign done_now_o = ~pend_q | ack_i;

endmodule

// File: rtl/mac_issue_ctrl.sv
// Issues operand tuples to the MAC FIFOs, buffers results, tracks in-flight tuples.
module mac_issue_ctrl
  import mac_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned MAX_OUT  = DefMaxOut,
  parameter int unsigned CNT_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  mac_issue_ctrl_if.master    bus,
  output logic [CNT_BITS-1:0] outstanding,
  output logic                busy,
  output logic                err_unexpected
);

  localparam logic [CNT_BITS-1:0] MaxOutC = CNT_BITS'(MAX_OUT);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] out_q, out_d;
  logic                err_q, err_d;
  logic                res_stb_q, res_stb_d;
  logic [WIDTH-1:0]    res_data_q, res_data_d;
  logic [NumCh-1:0]    done;
  logic                load, issue, retire, cmd_ack;

  stb_chan_tx #(.WIDTH(WIDTH)) u_chan_a (
    .clk(clk), .rst(rst), .load_i(load), .data_i(bus.cmd_a), .ack_i(bus.mac_a_ack),
    .stb_o(bus.mac_a_stb), .data_o(bus.mac_a), .done_now_o(done[ChA])
  );
  stb_chan_tx #(.WIDTH(WIDTH)) u_chan_b (
    .clk(clk), .rst(rst), .load_i(load), .data_i(bus.cmd_b), .ack_i(bus.mac_b_ack),
    .stb_o(bus.mac_b_stb), .data_o(bus.mac_b), .done_now_o(done[ChB])
  );
  stb_chan_tx #(.WIDTH(WIDTH)) u_chan_c (
    .clk(clk), .rst(rst), .load_i(load), .data_i(bus.cmd_c), .ack_i(bus.mac_c_ack),
    .stb_o(bus.mac_c_stb), .data_o(bus.mac_c), .done_now_o(done[ChC])
  );
  stb_chan_tx #(.WIDTH(1)) u_chan_op (
    .clk(clk), .rst(rst), .load_i(load), .data_i(bus.cmd_op), .ack_i(bus.mac_op_ack),
    .stb_o(bus.mac_op_stb), .data_o(bus.mac_op), .done_now_o(done[ChOp])
  );

  always_comb begin
    state_d = state_q;
    cmd_ack = 1'b0;
    load    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ack = (out_q < MaxOutC);
        if (bus.cmd_stb && cmd_ack) begin
          load    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (&done) begin
          issue   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // One-entry result buffer; a drain and a load in the same cycle keeps it full.
  assign bus.mac_ans_ack = ~res_stb_q | bus.res_ack;
  assign retire          = bus.mac_ans_stb & bus.mac_ans_ack;

  always_comb begin
    res_stb_d  = res_stb_q;
    res_data_d = res_data_q;
    if (retire) begin
      res_stb_d  = 1'b1;
      res_data_d = bus.mac_ans;
    end else if (bus.res_ack) begin
      res_stb_d  = 1'b0;
    end
  end

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    unique case ({issue, retire})
      2'b10: out_d = out_q + 1'b1;
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else             out_d = out_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      out_q     <= '0;
      err_q     <= 1'b0;
      res_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      err_q     <= err_d;
      res_stb_q <= res_stb_d;
    end
  end

  always_ff @(posedge clk) begin
    res_data_q <= res_data_d;
  end

  assign bus.cmd_ack    = cmd_ack;
  assign bus.res_stb    = res_stb_q;
  assign bus.res_data   = res_data_q;
  assign outstanding    = out_q;
  assign busy           = (state_q == StIssue) || (out_q != '0);
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// Directed table-driven bench for mac_issue_ctrl, plus throttle and reset sequences.
module tb_mac_issue_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned MO = 4;
  localparam int unsigned CB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CB-1:0] outstanding;
  logic          busy, err_unexpected;

  mac_issue_ctrl_if #(.WIDTH(W)) bus ();

  mac_issue_ctrl #(.WIDTH(W), .MAX_OUT(MO), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .outstanding(outstanding), .busy(busy), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, cstb; logic [31:0] a, b, c; logic op; logic [3:0] acks;
    logic as; logic [31:0] ans; logic rk;
    logic chk, cack; logic [3:0] stb; logic [2:0] out; logic bz, rs;
    logic [31:0] rd; logic aa, er;
  } vec_t;

  vec_t vt[$];
  int total = 0;
  int bad   = 0;
  logic [31:0] ta, tb, tc;
  logic        top;
  int          accepts;

  function automatic vec_t v(
    input logic rst_v, cstb, input logic [31:0] a, b, c, input logic op,
    input logic [3:0] acks, input logic as, input logic [31:0] ans, input logic rk,
    input logic chk, cack, input logic [3:0] stb, input logic [2:0] out,
    input logic bz, rs, input logic [31:0] rd, input logic aa, er);
    vec_t r;
    r.rst = rst_v; r.cstb = cstb; r.a = a; r.b = b; r.c = c; r.op = op; r.acks = acks;
    r.as = as; r.ans = ans; r.rk = rk; r.chk = chk; r.cack = cack; r.stb = stb;
    r.out = out; r.bz = bz; r.rs = rs; r.rd = rd; r.aa = aa; r.er = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acks(input logic [3:0] k);
    bus.mac_a_ack = k[0]; bus.mac_b_ack = k[1]; bus.mac_c_ack = k[2]; bus.mac_op_ack = k[3];
  endtask

  function automatic logic [3:0] stbs();
    return {bus.mac_op_stb, bus.mac_c_stb, bus.mac_b_stb, bus.mac_a_stb};
  endfunction

  initial begin
    rst = 1'b1;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_c = '0; bus.cmd_op = 1'b0; bus.cmd_stb = 1'b0;
    set_acks(4'hF);
    bus.mac_ans = '0; bus.mac_ans_stb = 1'b0; bus.res_ack = 1'b1;
    ta = '0; tb = '0; tc = '0; top = 1'b0;

    //           rst cs  a             b             c             op acks  as ans           rk
    //           chk ca  stb   out bz rs rd            aa er
    vt.push_back(v(1, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 1, 4'h0, 0, 0, 0, 0, 1, 0));
    vt.push_back(v(0, 1, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 4'hF, 0, 0, 1,
                   1, 1, 4'h0, 0, 0, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 0, 4'hF, 0, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 1, 4'h0, 1, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 1, 32'h11111111, 32'h22222222, 32'h33333333, 1, 4'hF, 0, 0, 1,
                   1, 1, 4'h0, 1, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'h5, 0, 0, 1,  1, 0, 4'hF, 1, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1,  1, 0, 4'hA, 1, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1,  1, 0, 4'hA, 1, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'h2, 0, 0, 1,  1, 0, 4'hA, 1, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1,  1, 0, 4'h8, 1, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'h8, 0, 0, 1,  1, 0, 4'h8, 1, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 1, 4'h0, 2, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 1, 32'hDEADBEEF, 0,
                   1, 1, 4'h0, 2, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 1, 32'h12345678, 0,
                   1, 1, 4'h0, 1, 1, 1, 32'hDEADBEEF, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 1, 32'h12345678, 1,
                   1, 1, 4'h0, 1, 1, 1, 32'hDEADBEEF, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 1, 4'h0, 0, 0, 1, 32'h12345678, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 1, 4'h0, 0, 0, 0, 0, 1, 0));
    vt.push_back(v(0, 1, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 1, 4'hF, 0, 0, 1,
                   1, 1, 4'h0, 0, 0, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 1, 32'hCAFEF00D, 1,
                   1, 0, 4'hF, 0, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 1, 4'h0, 0, 0, 1, 32'hCAFEF00D, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 1, 32'h0BADF00D, 1,
                   1, 1, 4'h0, 0, 0, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 1, 4'h0, 0, 0, 1, 32'h0BADF00D, 1, 1));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 1,  1, 1, 4'h0, 0, 0, 0, 0, 1, 1));

    foreach (vt[i]) begin
      rst = vt[i].rst; bus.cmd_stb = vt[i].cstb;
      bus.cmd_a = vt[i].a; bus.cmd_b = vt[i].b; bus.cmd_c = vt[i].c; bus.cmd_op = vt[i].op;
      set_acks(vt[i].acks);
      bus.mac_ans_stb = vt[i].as; bus.mac_ans = vt[i].ans; bus.res_ack = vt[i].rk;
      #2;
      if (vt[i].chk) begin
        chk($sformatf("r%0d cmd_ack", i), 64'(bus.cmd_ack), 64'(vt[i].cack));
        chk($sformatf("r%0d stb", i), 64'(stbs()), 64'(vt[i].stb));
        chk($sformatf("r%0d outstanding", i), 64'(outstanding), 64'(vt[i].out));
        chk($sformatf("r%0d busy", i), 64'(busy), 64'(vt[i].bz));
        chk($sformatf("r%0d res_stb", i), 64'(bus.res_stb), 64'(vt[i].rs));
        chk($sformatf("r%0d mac_ans_ack", i), 64'(bus.mac_ans_ack), 64'(vt[i].aa));
        chk($sformatf("r%0d err", i), 64'(err_unexpected), 64'(vt[i].er));
        if (vt[i].rs) chk($sformatf("r%0d res_data", i), 64'(bus.res_data), 64'(vt[i].rd));
        if (vt[i].stb[0]) chk($sformatf("r%0d mac_a", i), 64'(bus.mac_a), 64'(ta));
        if (vt[i].stb[1]) chk($sformatf("r%0d mac_b", i), 64'(bus.mac_b), 64'(tb));
        if (vt[i].stb[2]) chk($sformatf("r%0d mac_c", i), 64'(bus.mac_c), 64'(tc));
        if (vt[i].stb[3]) chk($sformatf("r%0d mac_op", i), 64'(bus.mac_op), 64'(top));
      end
      if (vt[i].cstb && vt[i].cack) begin
        ta = vt[i].a; tb = vt[i].b; tc = vt[i].c; top = vt[i].op;
      end
      cyc();
    end

    // Reset clears the sticky error left by the table.
    bus.cmd_stb = 1'b0; bus.mac_ans_stb = 1'b0; bus.res_ack = 1'b1; set_acks(4'hF);
    rst = 1'b1; cyc(); rst = 1'b0; #2;
    chk("reset err", 64'(err_unexpected), 64'd0);
    chk("reset outstanding", 64'(outstanding), 64'd0);
    chk("reset cmd_ack", 64'(bus.cmd_ack), 64'd1);
    cyc();

    // Throttle: continuous commands, no results.
    accepts = 0;
    bus.cmd_stb = 1'b1;
    for (int n = 0; n < 20; n++) begin
      bus.cmd_a = 32'h100 + 32'(n);
      #2;
      if (bus.cmd_ack) accepts++;
      cyc();
    end
    #2;
    chk("throttle accepts", 64'(accepts), 64'd4);
    chk("throttle outstanding", 64'(outstanding), 64'd4);
    chk("throttle cmd_ack", 64'(bus.cmd_ack), 64'd0);
    chk("throttle busy", 64'(busy), 64'd1);
    bus.mac_ans_stb = 1'b1; bus.mac_ans = 32'h1;
    cyc();
    bus.mac_ans_stb = 1'b0; #2;
    chk("retire outstanding", 64'(outstanding), 64'd3);
    chk("retire cmd_ack", 64'(bus.cmd_ack), 64'd1);
    cyc();
    // Fifth tuple completes in the same cycle as a retire.
    bus.cmd_stb = 1'b0; bus.mac_ans_stb = 1'b1; bus.mac_ans = 32'h2; #2;
    chk("fifth stb", 64'(stbs()), 64'hF);
    cyc();
    bus.mac_ans_stb = 1'b0; #2;
    chk("issue+retire outstanding", 64'(outstanding), 64'd3);
    chk("issue+retire err", 64'(err_unexpected), 64'd0);

    // Reset while op and b are still pending.
    bus.cmd_stb = 1'b1; bus.cmd_a = 32'h55; bus.cmd_b = 32'h66; bus.cmd_c = 32'h77;
    bus.cmd_op = 1'b1;
    cyc();
    bus.cmd_stb = 1'b0; set_acks(4'h5); #2;
    chk("mid stb all", 64'(stbs()), 64'hF);
    cyc();
    set_acks(4'h0); #2;
    chk("mid pend", 64'(stbs()), 64'hA);
    chk("mid mac_b", 64'(bus.mac_b), 64'h66);
    chk("mid mac_op", 64'(bus.mac_op), 64'd1);
    rst = 1'b1; cyc(); rst = 1'b0; #2;
    chk("rst stb", 64'(stbs()), 64'h0);
    chk("rst outstanding", 64'(outstanding), 64'd0);
    chk("rst err", 64'(err_unexpected), 64'd0);
    chk("rst cmd_ack", 64'(bus.cmd_ack), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst res_stb", 64'(bus.res_stb), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
